// File: rtl/intr_cfg_seq_pkg.sv
// Shared definitions for the interrupt-controller priority configuration
// sequencer: default geometry, sequencer state encoding, run mode encoding
// and the APB phase encoding used by the bus master.
package intr_cfg_seq_pkg;

    localparam int DefNumRegs = 16;
    localparam int DefAddrW   = 4;
    localparam int DefDataW   = 4;

    // One-hot sequencer states, in the same style as the other controllers.
    typedef enum logic [5:0] {
        ST_IDLE     = 6'b000001,
        ST_W_SETUP  = 6'b000010,
        ST_W_ACCESS = 6'b000100,
        ST_R_SETUP  = 6'b001000,
        ST_R_ACCESS = 6'b010000,
        ST_DONE     = 6'b100000
    } seqState_e;

    // A run either sweeps the whole table or writes one register.
    typedef enum logic {
        MODE_BULK   = 1'b0,
        MODE_SINGLE = 1'b1
    } seqMode_e;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_ACCESS = 2'd2
    } apbPhase_e;

endpackage

// File: rtl/intr_cfg_seq_apb.sv
// APB master phase engine.
// Accepts one transfer request (issue_i with addr/wdata/write) and drives a
// SETUP cycle followed by ACCESS cycles until pready or until the timeout
// budget is used up.
// Ports:
//   pclk_i, prst_i          clock, synchronous active-low reset
//   issue_i                 load a new transfer; SETUP is driven next cycle
//   addr_i, wdata_i, write_i transfer description
//   pready_i, prdata_i      APB slave response
//   paddr_o, pwdata_o, pwrite_o, penable_o  registered APB request
//   rdata_o                 read data of the completing transfer
//   complete_o              ACCESS cycle in which pready is seen
//   timed_out_o             last allowed ACCESS cycle with pready still low
module apb_master_if
    import intr_cfg_seq_pkg::*;
#(
    parameter int ADDR_W  = DefAddrW,
    parameter int DATA_W  = DefDataW,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic              pclk_i,
    input  logic              prst_i,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              write_i,
    input  logic              pready_i,
    input  logic [DATA_W-1:0] prdata_i,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    output logic              pwrite_o,
    output logic              penable_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              complete_o,
    output logic              timed_out_o
);

    apbPhase_e         phase_q;
    logic [TO_W-1:0]   waitCnt_q;
    logic              inAccess;

    assign inAccess    = (phase_q == PH_ACCESS);
    assign complete_o  = inAccess && pready_i;
    assign timed_out_o = inAccess && !pready_i && (waitCnt_q == TO_W'(TIMEOUT - 1));
    assign rdata_o     = prdata_i;

    // Phase sequencing. A new issue always wins so the sequencer can chain
    // transfers with no idle cycle. When a transfer ends without a follow-up
    // the bus returns to all-zero. The wait counter counts stalled ACCESS
    // cycles and restarts at every SETUP.
    always_ff @(posedge pclk_i) begin
        if (!prst_i) begin
            phase_q   <= PH_IDLE;
            waitCnt_q <= '0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
            pwrite_o  <= 1'b0;
            penable_o <= 1'b0;
        end else if (issue_i) begin
            phase_q   <= PH_SETUP;
            waitCnt_q <= '0;
            paddr_o   <= addr_i;
            pwdata_o  <= wdata_i;
            pwrite_o  <= write_i;
            penable_o <= 1'b0;
        end else begin
            case (phase_q)
                PH_SETUP: begin
                    phase_q   <= PH_ACCESS;
                    waitCnt_q <= '0;
                    penable_o <= 1'b1;
                end
                PH_ACCESS: begin
                    if (pready_i || timed_out_o) begin
                        phase_q   <= PH_IDLE;
                        paddr_o   <= '0;
                        pwdata_o  <= '0;
                        pwrite_o  <= 1'b0;
                        penable_o <= 1'b0;
                    end else begin
                        waitCnt_q <= waitCnt_q + TO_W'(1);
                    end
                end
                default: begin
                    phase_q   <= PH_IDLE;
                    penable_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/intr_cfg_seq.sv
// APB configuration sequencer for the interrupt controller priority file.
// A start pulse writes every table entry (optionally reading each back and
// comparing); single-register update requests are served between runs.
// Ports:
//   pclk_i, prst_i              clock, synchronous active-low reset
//   start_i, cfg_table_i        bulk run request and the table to program
//   upd_req_i/upd_addr_i/upd_data_i, upd_ack_o  single-register update handshake
//   busy_o, done_o              run in progress / one-cycle end-of-run pulse
//   err_o, err_addr_o, timeout_o  sticky run status, cleared on next accept
//   paddr_o..penable_o, pready_i, prdata_i  APB master port
module intr_cfg_seq
    import intr_cfg_seq_pkg::*;
#(
    parameter int NUM_REGS = DefNumRegs,
    parameter int ADDR_W   = DefAddrW,
    parameter int DATA_W   = DefDataW,
    parameter int VERIFY   = 1,
    parameter int TIMEOUT  = 15,
    parameter int TO_W     = 4
) (
    input  logic                       pclk_i,
    input  logic                       prst_i,
    input  logic                       start_i,
    input  logic [NUM_REGS*DATA_W-1:0] cfg_table_i,
    input  logic                       upd_req_i,
    input  logic [ADDR_W-1:0]          upd_addr_i,
    input  logic [DATA_W-1:0]          upd_data_i,
    output logic                       upd_ack_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [ADDR_W-1:0]          err_addr_o,
    output logic                       timeout_o,
    output logic [ADDR_W-1:0]          paddr_o,
    output logic                       pwrite_o,
    output logic [DATA_W-1:0]          pwdata_o,
    output logic                       penable_o,
    input  logic                       pready_i,
    input  logic [DATA_W-1:0]          prdata_i
);

    localparam bit DoVerify = (VERIFY != 0);

    seqState_e         state_q;
    seqMode_e          mode_q;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] table_q [NUM_REGS];
    logic [ADDR_W-1:0] updAddr_q;
    logic [DATA_W-1:0] updData_q;

    logic [ADDR_W-1:0] curAddr_d;
    logic [DATA_W-1:0] curData_d;
    logic [ADDR_W-1:0] nextIdx_d;
    logic              lastReg_d;
    logic              issue_d;
    logic [ADDR_W-1:0] issAddr_d;
    logic [DATA_W-1:0] issData_d;
    logic              issWrite_d;

    logic [DATA_W-1:0] rdata;
    logic              complete;
    logic              timedOut;

    assign curAddr_d = (mode_q == MODE_SINGLE) ? updAddr_q : idx_q;
    assign curData_d = (mode_q == MODE_SINGLE) ? updData_q : table_q[idx_q];
    assign nextIdx_d = idx_q + ADDR_W'(1);
    assign lastReg_d = (mode_q == MODE_SINGLE) || (idx_q == ADDR_W'(NUM_REGS - 1));

    // Transfer requests to the APB engine. They are raised on the same edge
    // the FSM leaves a state so the SETUP cycle follows immediately. On the
    // accepting edge the table and update registers are not loaded yet, so
    // the first transfer takes its values straight from the inputs.
    always_comb begin
        issue_d    = 1'b0;
        issAddr_d  = curAddr_d;
        issData_d  = curData_d;
        issWrite_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    issue_d   = 1'b1;
                    issAddr_d = '0;
                    issData_d = cfg_table_i[DATA_W-1:0];
                end else if (upd_req_i) begin
                    issue_d   = 1'b1;
                    issAddr_d = upd_addr_i;
                    issData_d = upd_data_i;
                end
            end
            ST_W_ACCESS: begin
                if (complete) begin
                    if (DoVerify) begin
                        issue_d    = 1'b1;
                        issWrite_d = 1'b0;
                        issData_d  = '0;
                    end else if (!lastReg_d) begin
                        issue_d   = 1'b1;
                        issAddr_d = nextIdx_d;
                        issData_d = table_q[nextIdx_d];
                    end
                end
            end
            ST_R_ACCESS: begin
                if (complete && !lastReg_d) begin
                    issue_d   = 1'b1;
                    issAddr_d = nextIdx_d;
                    issData_d = table_q[nextIdx_d];
                end
            end
            default: begin
                issue_d = 1'b0;
            end
        endcase
    end

    apb_master_if #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_apb (
        .pclk_i      (pclk_i),
        .prst_i      (prst_i),
        .issue_i     (issue_d),
        .addr_i      (issAddr_d),
        .wdata_i     (issData_d),
        .write_i     (issWrite_d),
        .pready_i    (pready_i),
        .prdata_i    (prdata_i),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .pwrite_o    (pwrite_o),
        .penable_o   (penable_o),
        .rdata_o     (rdata),
        .complete_o  (complete),
        .timed_out_o (timedOut)
    );

    // Sequencer FSM with registered status outputs. Start beats a
    // simultaneous update, which simply stays pending until the next IDLE.
    // A timeout abandons the rest of the run; a readback mismatch only
    // records the first failing address and the sweep carries on.
    always_ff @(posedge pclk_i) begin
        if (!prst_i) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_BULK;
            idx_q      <= '0;
            updAddr_q  <= '0;
            updData_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                table_q[i] <= '0;
            end
            upd_ack_o  <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_addr_o <= '0;
            timeout_o  <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            upd_ack_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            table_q[i] <= cfg_table_i[i*DATA_W +: DATA_W];
                        end
                        idx_q      <= '0;
                        mode_q     <= MODE_BULK;
                        err_o      <= 1'b0;
                        err_addr_o <= '0;
                        timeout_o  <= 1'b0;
                        busy_o     <= 1'b1;
                        state_q    <= ST_W_SETUP;
                    end else if (upd_req_i) begin
                        updAddr_q  <= upd_addr_i;
                        updData_q  <= upd_data_i;
                        upd_ack_o  <= 1'b1;
                        mode_q     <= MODE_SINGLE;
                        err_o      <= 1'b0;
                        err_addr_o <= '0;
                        timeout_o  <= 1'b0;
                        busy_o     <= 1'b1;
                        state_q    <= ST_W_SETUP;
                    end
                end
                ST_W_SETUP: begin
                    state_q <= ST_W_ACCESS;
                end
                ST_W_ACCESS, ST_R_ACCESS: begin
                    if (timedOut) begin
                        if (!err_o) begin
                            err_addr_o <= paddr_o;
                        end
                        err_o     <= 1'b1;
                        timeout_o <= 1'b1;
                        done_o    <= 1'b1;
                        state_q   <= ST_DONE;
                    end else if (complete) begin
                        if ((state_q == ST_R_ACCESS) && (rdata != curData_d) && !err_o) begin
                            err_o      <= 1'b1;
                            err_addr_o <= paddr_o;
                        end
                        if ((state_q == ST_W_ACCESS) && DoVerify) begin
                            state_q <= ST_R_SETUP;
                        end else if (lastReg_d) begin
                            done_o  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q   <= nextIdx_d;
                            state_q <= ST_W_SETUP;
                        end
                    end
                end
                ST_R_SETUP: begin
                    state_q <= ST_R_ACCESS;
                end
                ST_DONE: begin
                    busy_o  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_o  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
